// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC fetch front end.
// Optional macro FETCH_BYPASS_EN is consumed by fetch_stage.
package fetch_pkg;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] PC_INC      = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ibuf_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: small FIFO of {instr, pc} pairs.
// Flush empties it in one edge and overrides push/pop.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  ibuf_entry_t              data_i,
    input  logic                     pop_i,
    output ibuf_entry_t              data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ibuf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// WISC fetch stage: PC, single-outstanding imem requests, ibuf to decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when empty.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halt_seen,
    output logic        err
);

    localparam int CW = $clog2(IBUF_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  req_pc_q, req_pc_d;
    logic         out_q, out_d;
    logic         stale_q, stale_d;
    logic         err_q, err_d;

    ibuf_entry_t  head;
    logic [CW-1:0] count;
    logic         empty;
    logic         space;
    logic         issue;
    logic         resp_ok;
    logic         bypass;
    logic         push;
    logic         pop;

    assign space   = (int'(count) + int'(out_q)) < IBUF_DEPTH;
    assign issue   = (state_q == REQ) && !redirect && !out_q && space;
    assign resp_ok = imem_valid && out_q && !stale_q && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_ok && empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_ok && !(bypass && if_ready);
    assign pop  = !empty && if_ready;

    fetch_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  ({imem_rdata, req_pc_q}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            out_q    <= 1'b0;
            stale_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
            stale_q  <= stale_d;
            err_q    <= err_d;
        end
    end

    // Next state: redirect overrides everything; stale replies just retire.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        out_d    = out_q;
        stale_d  = stale_q;
        err_d    = err_q;
        if (redirect) begin
            state_d = REQ;
            pc_d    = {redirect_pc[15:1], 1'b0};
            out_d   = out_q && !imem_valid;
            stale_d = out_q && !imem_valid;
            err_d   = err_q | redirect_pc[0];
        end else begin
            if (imem_valid && out_q) begin
                out_d   = 1'b0;
                stale_d = 1'b0;
            end
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (issue) begin
                        out_d    = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_INC;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (resp_ok) begin
                        state_d = is_halt(imem_rdata) ? HALT : REQ;
                    end
                end
                HALT: state_d = HALT;
            endcase
        end
    end

    // Decode-facing view of the buffer head (or the bypassed word).
    always_comb begin
        if_valid = 1'b0;
        if_instr = NOP_INSTR;
        if_pc    = '0;
        if (!empty) begin
            if_valid = 1'b1;
            if_instr = head.instr;
            if_pc    = head.pc;
        end else if (bypass) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = req_pc_q;
        end
    end

    assign if_pc_plus2 = if_pc + PC_INC;
    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign halt_seen   = (state_q == HALT);
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory responder, stream model,
// directed scenarios and a randomized soak.
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halt_seen;
    logic        err;

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halt_seen   (halt_seen),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] p2;
    } dl_t;

    int          errors = 0;
    int          checks = 0;
    ent_t        q[$];
    dl_t         deliv[$];
    logic [15:0] req_log[$];
    logic [15:0] exp_pc;
    bit          halted, err_m, started, pending, pend_stale, release_now;
    logic [15:0] pend_addr;
    int          cnt;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          rand_halt = 1'b0;
    bit          halt_addr_en = 1'b0;
    logic [15:0] halt_addr = 16'h0110;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] h;
        if (a == 16'h0000) return 16'h4000;
        if (a == 16'h0002) return 16'h4001;
        if (halt_addr_en && a == halt_addr) return 16'h0000;
        if (rand_halt && a[6:0] == 7'h3E) return 16'h0000;
        h = (a * 16'h9E37) ^ 16'h5A5A;
        if (h[15:11] == 5'b00000) h[15:11] = 5'b10101;
        return h;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rdy, input bit redir,
                        input logic [15:0] rpc, input bit stray);
        bit          resp, exp_req, accepted;
        logic [15:0] w;
        dl_t         d;
        @(negedge clk);
        if (release_now) begin
            rst_n = 1'b1;
            release_now = 1'b0;
        end
        resp = 1'b0;
        if (pending) begin
            cnt--;
            resp = (cnt <= 0);
        end
        if_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_valid  = resp | stray;
        imem_rdata  = resp ? word_at(pend_addr) : 16'hDEAD;
        #1;
        exp_req = started && !redir && !pending && !halted && (q.size() < DEPTH);
        chk("imem_req", 16'(imem_req), 16'(exp_req));
        if (imem_req && exp_req) chk("imem_addr", imem_addr, exp_pc);
        if (q.size() > 0) begin
            chk("if_valid", 16'(if_valid), 16'h1);
            chk("if_instr", if_instr, q[0].instr);
            chk("if_pc", if_pc, q[0].pc);
            chk("if_pc_plus2", if_pc_plus2, q[0].pc + 16'd2);
        end else begin
            chk("if_valid_idle", 16'(if_valid), 16'h0);
            chk("if_instr_nop", if_instr, 16'h0800);
        end
        chk("halt_seen", 16'(halt_seen), 16'(halted));
        chk("err", 16'(err), 16'(err_m));
        if (redir) begin
            q.delete();
            exp_pc = {rpc[15:1], 1'b0};
            halted = 1'b0;
            if (rpc[0]) err_m = 1'b1;
            if (resp) pending = 1'b0;
            else if (pending) pend_stale = 1'b1;
        end else begin
            accepted = resp && !pend_stale;
            if (accepted) begin
                checks++;
                assert (q.size() < DEPTH) else begin
                    errors++;
                    $display("FAIL ibuf_space: response with %0d entries held", q.size());
                end
            end
            if (q.size() > 0 && rdy) begin
                d = '{if_instr, if_pc, if_pc_plus2};
                deliv.push_back(d);
                void'(q.pop_front());
            end
            if (resp) begin
                pending = 1'b0;
                if (accepted) begin
                    w = word_at(pend_addr);
                    q.push_back('{w, pend_addr});
                    if (w[15:11] == 5'b00000) halted = 1'b1;
                end
            end
        end
        if (exp_req) begin
            pending    = 1'b1;
            pend_stale = 1'b0;
            pend_addr  = exp_pc;
            cnt        = $urandom_range(lat_hi, lat_lo);
            exp_pc     = exp_pc + 16'd2;
        end
        if (imem_req) req_log.push_back(imem_addr);
        if (rst_n) started = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n      = 1'b0;
        redirect   = 1'b0;
        if_ready   = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h0000;
        #1;
        chk("rst_imem_req", 16'(imem_req), 16'h0);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_if_valid", 16'(if_valid), 16'h0);
        chk("rst_if_instr", if_instr, 16'h0800);
        chk("rst_if_pc", if_pc, 16'h0000);
        chk("rst_halt", 16'(halt_seen), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        repeat (n) @(negedge clk);
        q.delete();
        exp_pc     = 16'h0000;
        halted     = 1'b0;
        err_m      = 1'b0;
        started    = 1'b0;
        pending    = 1'b0;
        pend_stale = 1'b0;
        release_now = 1'b1;
        step(1'b1, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        int n0, n1;
        bit found;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
        do_reset(3);

        lat_lo = 1; lat_hi = 1;
        repeat (12) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("seq_addr0", req_log[0], 16'h0000);
        chk("seq_addr1", req_log[1], 16'h0002);
        chk("seq_addr2", req_log[2], 16'h0004);
        chk("first_instr", deliv[0].instr, 16'h4000);
        chk("first_pc", deliv[0].pc, 16'h0000);
        chk("first_p2", deliv[0].p2, 16'h0002);
        chk("second_instr", deliv[1].instr, 16'h4001);
        chk("second_pc", deliv[1].pc, 16'h0002);
        chk("second_p2", deliv[1].p2, 16'h0004);

        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b0);
        n0 = req_log.size();
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("stall_no_req", 16'(req_log.size() - n0), 16'h0);
        chk("stall_valid", 16'(if_valid), 16'h1);
        repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);

        lat_lo = 3; lat_hi = 3;
        halt_addr_en = 1'b1;
        for (int i = 0; i < 20 && !(pending && cnt == 3); i++)
            step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("redir_outstanding", 16'(pending), 16'h1);
        n0 = req_log.size();
        step(1'b1, 1'b1, 16'h0100, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("post_redir_valid", 16'(if_valid), 16'h0);
        repeat (12) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("redir_addr", req_log[n0], 16'h0100);

        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 150 && !halt_seen; i++)
            step($urandom_range(99, 0) < 70, 1'b0, 16'h0, 1'b0);
        chk("halt_set", 16'(halt_seen), 16'h1);
        n0 = req_log.size();
        repeat (10) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("halt_no_req", 16'(req_log.size() - n0), 16'h0);
        chk("halt_drained", 16'(if_valid), 16'h0);
        chk("halt_last_instr", deliv[$].instr, 16'h0000);
        chk("halt_last_pc", deliv[$].pc, 16'h0110);
        halt_addr_en = 1'b0;
        n0 = req_log.size();
        step(1'b1, 1'b1, 16'h0040, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("halt_cleared", 16'(halt_seen), 16'h0);
        repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("resume_addr", req_log[n0], 16'h0040);

        n0 = req_log.size();
        step(1'b1, 1'b1, 16'h0103, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("err_set", 16'(err), 16'h1);
        repeat (8) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("odd_redir_addr", req_log[n0], 16'h0102);
        chk("err_sticky", 16'(err), 16'h1);

        n0 = req_log.size();
        n1 = deliv.size();
        step(1'b1, 1'b1, 16'hFFFC, 1'b0);
        repeat (14) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("wrap_addr0", req_log[n0], 16'hFFFC);
        chk("wrap_addr1", req_log[n0 + 1], 16'hFFFE);
        chk("wrap_addr2", req_log[n0 + 2], 16'h0000);
        found = 1'b0;
        for (int i = n1; i < deliv.size(); i++) begin
            if (!found && deliv[i].pc == 16'hFFFE) begin
                found = 1'b1;
                chk("wrap_p2", deliv[i].p2, 16'h0000);
            end
        end
        chk("wrap_delivered", 16'(found), 16'h1);

        lat_lo = 1; lat_hi = 4;
        rand_halt = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                do_reset(2);
            end else begin
                step($urandom_range(99, 0) < 70,
                     started && ($urandom_range(49, 0) == 0),
                     16'($urandom), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
